dm_ctl: RTL and testbench

Data-memory access controller for the SISC processor: the initiator side of the data-memory port. It accepts load/store requests from the core over a valid/ready handshake and drives `read_addr`, `write_addr`, `write_data` and `dm_we` toward data memory. Data memory commits a write on the falling edge of `dm_we` and returns combinational `read_data`. Stores are absorbed into a small store buffer and drained as `dm_we` pulses. Loads that hit a buffered store are forwarded; all other loads are read from memory after a fixed settle time.

---
 rtl/sisc_pkg.sv | 26 ++
 rtl/dm_stbuf.sv | 74 +++++++
 rtl/dm_ctl.sv | 187 ++++++++++++++++++
 tb/tb_dm_ctl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions for the data-memory controller: bus widths, FSM state
// encodings and the store-buffer entry layout.
package sisc_pkg;

    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 32;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_FWD,
        LD_WAIT,
        LD_RSP
    } ld_state_e;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_HIGH,
        DR_LOW
    } dr_state_e;

    typedef struct packed {
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/dm_stbuf.sv
// Circular store buffer of {addr, data} entries with a combinational lookup
// that reports the youngest valid entry matching a given address.
module dm_stbuf
    import sisc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  sb_entry_t            pushEntry_i,
    input  logic                 pop_i,
    output sb_entry_t            head_o,
    output logic                 empty_o,
    output logic                 full_o,
    input  logic [DM_ADDR_W-1:0] lookupAddr_i,
    output logic                 lookupHit_o,
    output logic [DM_DATA_W-1:0] lookupData_o
);

    localparam int PtrW = $clog2(DEPTH);

    sb_entry_t        entries_q [DEPTH];
    logic [PtrW-1:0]  wrPtr_q;
    logic [PtrW-1:0]  rdPtr_q;
    logic [PtrW:0]    count_q;
    logic             pushEn;
    logic             popEn;
    logic [PtrW-1:0]  lookIdx;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PtrW+1)'(DEPTH));
    assign pushEn  = push_i && !full_o;
    assign popEn   = pop_i && !empty_o;
    assign head_o  = entries_q[rdPtr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushEn) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (popEn) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_q + {{PtrW{1'b0}}, pushEn} - {{PtrW{1'b0}}, popEn};
        end
    end

    // Payload storage needs no reset; only slots counted by count_q are ever read.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            entries_q[wrPtr_q] <= pushEntry_i;
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        lookupHit_o  = 1'b0;
        lookupData_o = '0;
        lookIdx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lookIdx = rdPtr_q + PtrW'(k);
            if (((PtrW+1)'(k) < count_q) && (entries_q[lookIdx].addr == lookupAddr_i)) begin
                lookupHit_o  = 1'b1;
                lookupData_o = entries_q[lookIdx].data;
            end
        end
    end

endmodule

// File: rtl/dm_ctl.sv
// Data-memory access controller: load FSM with store-to-load forwarding and a
// drain FSM that turns buffered stores into dm_we pulses (commit on falling edge).
module dm_ctl
    import sisc_pkg::*;
#(
    parameter int SB_DEPTH = 2,
    parameter int RD_WAIT  = 1,
    parameter int WE_HIGH  = 1
) (
    input  logic                 CLK,
    input  logic                 RST_F,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [DM_ADDR_W-1:0] req_addr,
    input  logic [DM_DATA_W-1:0] req_wdata,
    output logic                 rsp_valid,
    output logic [DM_DATA_W-1:0] rsp_data,
    output logic [DM_ADDR_W-1:0] read_addr,
    output logic [DM_ADDR_W-1:0] write_addr,
    output logic [DM_DATA_W-1:0] write_data,
    output logic                 dm_we,
    input  logic [DM_DATA_W-1:0] read_data
);

    localparam int WaitW = $clog2(RD_WAIT + 1);
    localparam int WeW   = $clog2(WE_HIGH + 1);

    ld_state_e            ldState_q, ldState_d;
    logic [WaitW-1:0]     waitCnt_q, waitCnt_d;
    logic [DM_DATA_W-1:0] fwdData_q, fwdData_d;
    logic [DM_ADDR_W-1:0] readAddr_q, readAddr_d;
    logic                 rspValid_q, rspValid_d;
    logic [DM_DATA_W-1:0] rspData_q, rspData_d;

    dr_state_e            drState_q, drState_d;
    logic [WeW-1:0]       weCnt_q, weCnt_d;
    logic [DM_ADDR_W-1:0] writeAddr_q, writeAddr_d;
    logic [DM_DATA_W-1:0] writeData_q, writeData_d;
    logic                 dmWe_q, dmWe_d;

    logic                 ldAccept;
    logic                 stAccept;
    logic                 sbPop;
    logic                 sbFull;
    logic                 sbEmpty;
    sb_entry_t            sbHead;
    sb_entry_t            pushEntry;
    logic                 lookupHit;
    logic [DM_DATA_W-1:0] lookupData;

    assign req_ready  = (ldState_q == LD_IDLE) && !sbFull;
    assign ldAccept   = req_valid && req_ready && !req_we;
    assign stAccept   = req_valid && req_ready && req_we;
    assign pushEntry  = '{addr: req_addr, data: req_wdata};

    assign rsp_valid  = rspValid_q;
    assign rsp_data   = rspData_q;
    assign read_addr  = readAddr_q;
    assign write_addr = writeAddr_q;
    assign write_data = writeData_q;
    assign dm_we      = dmWe_q;

    dm_stbuf #(
        .DEPTH(SB_DEPTH)
    ) u_stbuf (
        .clk_i        (CLK),
        .rst_ni       (RST_F),
        .push_i       (stAccept),
        .pushEntry_i  (pushEntry),
        .pop_i        (sbPop),
        .head_o       (sbHead),
        .empty_o      (sbEmpty),
        .full_o       (sbFull),
        .lookupAddr_i (req_addr),
        .lookupHit_o  (lookupHit),
        .lookupData_o (lookupData)
    );

    // Forwarded data is captured at acceptance because the matching entry may pop that same edge.
    always_comb begin
        ldState_d  = ldState_q;
        waitCnt_d  = waitCnt_q;
        fwdData_d  = fwdData_q;
        readAddr_d = readAddr_q;
        rspValid_d = 1'b0;
        rspData_d  = rspData_q;
        case (ldState_q)
            LD_IDLE: begin
                if (ldAccept) begin
                    if (lookupHit) begin
                        fwdData_d = lookupData;
                        ldState_d = LD_FWD;
                    end else begin
                        readAddr_d = req_addr;
                        waitCnt_d  = '0;
                        ldState_d  = LD_WAIT;
                    end
                end
            end
            LD_FWD: begin
                rspData_d  = fwdData_q;
                rspValid_d = 1'b1;
                ldState_d  = LD_RSP;
            end
            LD_WAIT: begin
                if (waitCnt_q == WaitW'(RD_WAIT)) begin
                    rspData_d  = read_data;
                    rspValid_d = 1'b1;
                    ldState_d  = LD_RSP;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            LD_RSP: begin
                ldState_d = LD_IDLE;
            end
            default: begin
                ldState_d = LD_IDLE;
            end
        endcase
    end

    // DR_LOW may launch the next pulse directly, giving one low cycle between stores.
    always_comb begin
        drState_d   = drState_q;
        weCnt_d     = weCnt_q;
        writeAddr_d = writeAddr_q;
        writeData_d = writeData_q;
        dmWe_d      = dmWe_q;
        sbPop       = 1'b0;
        case (drState_q)
            DR_IDLE, DR_LOW: begin
                drState_d = DR_IDLE;
                if (!sbEmpty) begin
                    writeAddr_d = sbHead.addr;
                    writeData_d = sbHead.data;
                    dmWe_d      = 1'b1;
                    weCnt_d     = WeW'(1);
                    drState_d   = DR_HIGH;
                end
            end
            DR_HIGH: begin
                if (weCnt_q == WeW'(WE_HIGH)) begin
                    dmWe_d    = 1'b0;
                    sbPop     = 1'b1;
                    drState_d = DR_LOW;
                end else begin
                    weCnt_d = weCnt_q + 1'b1;
                end
            end
            default: begin
                dmWe_d    = 1'b0;
                drState_d = DR_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            ldState_q   <= LD_IDLE;
            waitCnt_q   <= '0;
            fwdData_q   <= '0;
            readAddr_q  <= '0;
            rspValid_q  <= 1'b0;
            rspData_q   <= '0;
            drState_q   <= DR_IDLE;
            weCnt_q     <= '0;
            writeAddr_q <= '0;
            writeData_q <= '0;
            dmWe_q      <= 1'b0;
        end else begin
            ldState_q   <= ldState_d;
            waitCnt_q   <= waitCnt_d;
            fwdData_q   <= fwdData_d;
            readAddr_q  <= readAddr_d;
            rspValid_q  <= rspValid_d;
            rspData_q   <= rspData_d;
            drState_q   <= drState_d;
            weCnt_q     <= weCnt_d;
            writeAddr_q <= writeAddr_d;
            writeData_q <= writeData_d;
            dmWe_q      <= dmWe_d;
        end
    end

endmodule

// File: tb/tb_dm_ctl.sv
// Bench for dm_ctl: a transaction-level model predicts every output cycle by cycle,
// and directed scenarios pin key values with hand-computed literals.
module tb_dm_ctl;

    localparam int SB_DEPTH = 2;
    localparam int RD_WAIT  = 1;
    localparam int WE_HIGH  = 1;

    logic        CLK       = 1'b0;
    logic        RST_F     = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [15:0] read_addr;
    logic [15:0] write_addr;
    logic [31:0] write_data;
    logic        dm_we;
    logic [31:0] read_data;

    int vecCount  = 0;
    int missCount = 0;
    bit checkEn   = 1'b0;

    dm_ctl #(
        .SB_DEPTH(SB_DEPTH),
        .RD_WAIT (RD_WAIT),
        .WE_HIGH (WE_HIGH)
    ) dut (
        .CLK       (CLK),
        .RST_F     (RST_F),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .read_addr (read_addr),
        .write_addr(write_addr),
        .write_data(write_data),
        .dm_we     (dm_we),
        .read_data (read_data)
    );

    always #5 CLK = ~CLK;

    // Data memory: combinational read, write committed on the falling edge of dm_we.
    logic [31:0] benchMem [0:65535];
    logic [15:0] capAddr;
    logic [31:0] capData;
    bit          capValid = 1'b0;
    logic [15:0] commitLog [$];

    assign read_data = benchMem[read_addr];

    always @(posedge CLK) begin
        #1;
        if (dm_we) begin
            capAddr  = write_addr;
            capData  = write_data;
            capValid = 1'b1;
        end
    end

    always @(negedge dm_we) begin
        if (capValid) begin
            benchMem[capAddr] = capData;
            commitLog.push_back(capAddr);
            capValid = 1'b0;
        end
    end

    // Transaction-level model: stores are scheduled arithmetically on the drain timeline.
    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          startEdge;
        int          fallEdge;
    } StoreRec;

    StoreRec     pend [$];
    logic [31:0] modelMem [0:65535];
    int          edgeNo   = 0;
    int          lastFall = -100;
    int          loadDue  = -100;
    logic [31:0] loadData = '0;
    bit          modelAcc = 1'b0;
    logic        expReady     = 1'b1;
    logic        expRspValid  = 1'b0;
    logic [31:0] expRspData   = '0;
    logic [15:0] expReadAddr  = '0;
    logic [15:0] expWriteAddr = '0;
    logic [31:0] expWriteData = '0;
    logic        expDmWe      = 1'b0;

    always @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            foreach (pend[i]) begin
                if (pend[i].startEdge <= edgeNo) begin
                    modelMem[pend[i].addr] = pend[i].data;
                end
            end
            pend.delete();
            lastFall     = -100;
            loadDue      = -100;
            modelAcc     = 1'b0;
            expReady     = 1'b1;
            expRspValid  = 1'b0;
            expRspData   = '0;
            expReadAddr  = '0;
            expWriteAddr = '0;
            expWriteData = '0;
            expDmWe      = 1'b0;
        end else begin
            int  s;
            bit  hit;
            logic [31:0] hitData;
            StoreRec rec;
            edgeNo   = edgeNo + 1;
            modelAcc = req_valid && expReady;
            if (modelAcc && !req_we) begin
                hit     = 1'b0;
                hitData = '0;
                foreach (pend[i]) begin
                    if (pend[i].addr == req_addr) begin
                        hit     = 1'b1;
                        hitData = pend[i].data;
                    end
                end
                if (hit) begin
                    loadDue  = edgeNo + 1;
                    loadData = hitData;
                end else begin
                    loadDue     = edgeNo + RD_WAIT + 1;
                    loadData    = modelMem[req_addr];
                    expReadAddr = req_addr;
                end
            end
            while (pend.size() > 0 && pend[0].fallEdge == edgeNo) begin
                modelMem[pend[0].addr] = pend[0].data;
                void'(pend.pop_front());
            end
            if (modelAcc && req_we) begin
                s = (edgeNo + 1 > lastFall + 1) ? edgeNo + 1 : lastFall + 1;
                rec.addr      = req_addr;
                rec.data      = req_wdata;
                rec.startEdge = s;
                rec.fallEdge  = s + WE_HIGH;
                pend.push_back(rec);
                lastFall = rec.fallEdge;
            end
            expRspValid = (loadDue == edgeNo);
            if (expRspValid) begin
                expRspData = loadData;
            end
            expDmWe = 1'b0;
            foreach (pend[i]) begin
                if (pend[i].startEdge <= edgeNo && edgeNo < pend[i].fallEdge) begin
                    expDmWe = 1'b1;
                end
                if (pend[i].startEdge == edgeNo) begin
                    expWriteAddr = pend[i].addr;
                    expWriteData = pend[i].data;
                end
            end
            expReady = !(edgeNo <= loadDue) && (pend.size() < SB_DEPTH);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (checkEn) begin
            checkOutput("req_ready",  {31'd0, req_ready}, {31'd0, expReady});
            checkOutput("rsp_valid",  {31'd0, rsp_valid}, {31'd0, expRspValid});
            checkOutput("rsp_data",   rsp_data, expRspData);
            checkOutput("read_addr",  {16'd0, read_addr}, {16'd0, expReadAddr});
            checkOutput("dm_we",      {31'd0, dm_we}, {31'd0, expDmWe});
            checkOutput("write_addr", {16'd0, write_addr}, {16'd0, expWriteAddr});
            checkOutput("write_data", write_data, expWriteData);
        end
    end

    task automatic applyStimulus(input bit we, input logic [15:0] addr, input logic [31:0] data,
                                 output int accEdge);
        bit accepted = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(posedge CLK);
            #1;
            if (modelAcc) accepted = 1'b1;
        end
        accEdge   = edgeNo;
        req_valid = 1'b0;
        if (!accepted) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL accept_timeout: addr 0x%04h not accepted within 50 cycles", addr);
        end
    endtask

    task automatic waitEdges(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    initial begin
        int eA;
        int eB;
        int eC;
        int e;
        for (int i = 0; i < 65536; i++) begin
            benchMem[i] = '0;
            modelMem[i] = '0;
        end
        benchMem[16'h0003] = 32'h0000_00AA;
        modelMem[16'h0003] = 32'h0000_00AA;
        benchMem[16'h0020] = 32'h1234_5678;
        modelMem[16'h0020] = 32'h1234_5678;

        @(posedge CLK);
        checkEn = 1'b1;
        waitEdges(2);
        $display("[TB] reset state");
        checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_dm_we", {31'd0, dm_we}, 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        #1 RST_F = 1'b1;
        waitEdges(1);

        $display("[TB] miss load from 0x0003");
        applyStimulus(1'b0, 16'h0003, 32'h0, e);
        checkOutput("miss_read_addr", {16'd0, read_addr}, 32'h0000_0003);
        waitEdges(1);
        checkOutput("miss_no_rsp_edge1", {31'd0, rsp_valid}, 32'd0);
        waitEdges(1);
        checkOutput("miss_rsp_valid_edge2", {31'd0, rsp_valid}, 32'd1);
        checkOutput("miss_rsp_data", rsp_data, 32'h0000_00AA);
        waitEdges(2);

        $display("[TB] single store 0x0005");
        applyStimulus(1'b1, 16'h0005, 32'hDEAD_BEEF, e);
        waitEdges(1);
        checkOutput("store_we_high", {31'd0, dm_we}, 32'd1);
        checkOutput("store_waddr", {16'd0, write_addr}, 32'h0000_0005);
        waitEdges(1);
        checkOutput("store_we_fell", {31'd0, dm_we}, 32'd0);
        checkOutput("store_mem5", benchMem[16'h0005], 32'hDEAD_BEEF);
        applyStimulus(1'b0, 16'h0005, 32'h0, e);
        waitEdges(2);
        checkOutput("readback_mem5", rsp_data, 32'hDEAD_BEEF);
        waitEdges(2);

        $display("[TB] forwarding from the store buffer");
        applyStimulus(1'b1, 16'h0007, 32'h0000_0011, eA);
        applyStimulus(1'b1, 16'h0007, 32'h0000_0022, eB);
        applyStimulus(1'b0, 16'h0007, 32'h0, eC);
        checkOutput("fwd_load_edge", eC - eA, 32'd3);
        waitEdges(1);
        checkOutput("fwd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("fwd_rsp_data", rsp_data, 32'h0000_0022);
        checkOutput("fwd_no_read", {16'd0, read_addr}, 32'h0000_0005);
        waitEdges(5);
        checkOutput("fwd_mem7", benchMem[16'h0007], 32'h0000_0022);

        $display("[TB] full buffer");
        commitLog.delete();
        applyStimulus(1'b1, 16'h0010, 32'h0000_0001, eA);
        applyStimulus(1'b1, 16'h0011, 32'h0000_0002, eB);
        checkOutput("full_ready_low", {31'd0, req_ready}, 32'd0);
        applyStimulus(1'b1, 16'h0012, 32'h0000_0003, eC);
        checkOutput("full_third_accept", eC - eA, 32'd3);
        waitEdges(8);
        checkOutput("full_commits", 32'(commitLog.size()), 32'd3);
        checkOutput("full_order0", {16'd0, commitLog[0]}, 32'h0000_0010);
        checkOutput("full_order1", {16'd0, commitLog[1]}, 32'h0000_0011);
        checkOutput("full_order2", {16'd0, commitLog[2]}, 32'h0000_0012);
        checkOutput("full_mem12", benchMem[16'h0012], 32'h0000_0003);
        applyStimulus(1'b0, 16'h0011, 32'h0, e);
        waitEdges(2);
        checkOutput("full_readback11", rsp_data, 32'h0000_0002);
        waitEdges(1);

        $display("[TB] reset during drain");
        applyStimulus(1'b1, 16'h0009, 32'h0000_0055, eA);
        applyStimulus(1'b1, 16'h000A, 32'h0000_0066, eB);
        checkOutput("rstdrain_we_high", {31'd0, dm_we}, 32'd1);
        #2 RST_F = 1'b0;
        #1;
        checkOutput("rstdrain_we_low", {31'd0, dm_we}, 32'd0);
        checkOutput("rstdrain_mem9", benchMem[16'h0009], 32'h0000_0055);
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_F = 1'b1;
        waitEdges(6);
        checkOutput("rstdrain_memA", benchMem[16'h000A], 32'h0000_0000);

        $display("[TB] reset during a load");
        applyStimulus(1'b0, 16'h0020, 32'h0, e);
        #2 RST_F = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_F = 1'b1;
        waitEdges(4);
        checkOutput("rstload_no_rsp", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rstload_read_addr", {16'd0, read_addr}, 32'd0);
        applyStimulus(1'b0, 16'h0020, 32'h0, e);
        waitEdges(2);
        checkOutput("load_0x20", rsp_data, 32'h1234_5678);
        applyStimulus(1'b0, 16'h0009, 32'h0, e);
        waitEdges(2);
        checkOutput("load_0x09", rsp_data, 32'h0000_0055);
        waitEdges(3);

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
